// File: rtl/trig_pulse_gen.sv
// trig_pulse_gen: register-write trigger generator for chip_reg.
// Each channel is a stretched pulse or a req/ack handshake; lost triggers set sticky miss flags.
module trig_pulse_gen #(
  parameter int          NUM_TRIG  = 4,
  parameter logic [10:0] TRIG_ADDR = 11'h00C,
  parameter logic [10:0] MISS_ADDR = 11'h00D,
  parameter logic [7:0]  TRIG_MASK = 8'h05,
  parameter logic [7:0]  HS_MASK   = 8'h00,
  parameter int          PULSE_LEN = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [10:0]         address,
  input  logic [7:0]          wdata,
  input  logic                xfc,
  input  logic [NUM_TRIG-1:0] ack,
  output logic [NUM_TRIG-1:0] trig,
  output logic [NUM_TRIG-1:0] miss
);

  localparam int            CW   = $clog2(PULSE_LEN + 1);
  localparam logic [CW-1:0] LOAD = CW'(PULSE_LEN);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  logic [7:0]          w_fire8;
  logic [7:0]          w_clr8;
  logic [NUM_TRIG-1:0] w_fire;
  logic [NUM_TRIG-1:0] w_clr;
  logic                w_unused;

  assign w_fire8 = (xfc && address == TRIG_ADDR) ? (wdata & TRIG_MASK) : 8'h00;
  assign w_clr8  = (xfc && address == MISS_ADDR) ? wdata : 8'h00;
  assign w_fire  = w_fire8[NUM_TRIG-1:0];
  assign w_clr   = w_clr8[NUM_TRIG-1:0];
  // wdata bits above NUM_TRIG and ack on pulse channels are don't-cares
  assign w_unused = ^{w_fire8, w_clr8, ack};

  for (genvar i = 0; i < NUM_TRIG; i++) begin : g_ch
    state_t r_st;
    state_t w_st_nx;
    logic   r_trig;
    logic   w_trig_nx;
    logic   r_miss;
    logic   w_lost;

    if (HS_MASK[i]) begin : g_hs
      always_comb begin
        w_st_nx   = r_st;
        w_trig_nx = r_trig;
        w_lost    = 1'b0;
        unique case (r_st)
          S_IDLE: begin
            if (w_fire[i]) begin
              w_st_nx   = S_BUSY;
              w_trig_nx = 1'b1;
            end
          end
          S_BUSY: begin
            // a fire coinciding with ack is a fresh, accepted request
            if (w_fire[i]) begin
              w_trig_nx = 1'b1;
              w_lost    = ~ack[i];
            end else if (ack[i]) begin
              w_st_nx   = S_IDLE;
              w_trig_nx = 1'b0;
            end
          end
        endcase
      end
    end else begin : g_pulse
      logic [CW-1:0] r_cnt;
      logic [CW-1:0] w_cnt_nx;

      always_comb begin
        w_st_nx   = r_st;
        w_cnt_nx  = r_cnt;
        w_trig_nx = r_trig;
        w_lost    = 1'b0;
        unique case (r_st)
          S_IDLE: begin
            if (w_fire[i]) begin
              w_st_nx   = S_BUSY;
              w_cnt_nx  = LOAD;
              w_trig_nx = 1'b1;
            end
          end
          S_BUSY: begin
            if (w_fire[i]) begin
              w_cnt_nx  = LOAD;
              w_trig_nx = 1'b1;
              w_lost    = 1'b1;
            end else if (r_cnt == CW'(1)) begin
              w_st_nx   = S_IDLE;
              w_cnt_nx  = '0;
              w_trig_nx = 1'b0;
            end else begin
              w_cnt_nx  = r_cnt - CW'(1);
            end
          end
        endcase
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) r_cnt <= '0;
        else     r_cnt <= w_cnt_nx;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_st   <= S_IDLE;
        r_trig <= 1'b0;
      end else begin
        r_st   <= w_st_nx;
        r_trig <= w_trig_nx;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst)           r_miss <= 1'b0;
      else if (w_lost)   r_miss <= 1'b1;
      else if (w_clr[i]) r_miss <= 1'b0;
    end

    assign trig[i] = r_trig;
    assign miss[i] = r_miss;
  end

endmodule
